maxv_top: RTL and testbench

//   Board-level top for a 6-LED, one-UART FPGA board. Endlessly transmits a fixed ASCII

---
 rtl/maxv_pkg.sv | 23 ++
 rtl/maxv_if.sv | 11 +
 rtl/maxv_uart_tx.sv | 109 ++++++++++
 rtl/maxv_top.sv | 65 ++++++
 tb/tb_maxv_top.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/maxv_pkg.sv
// Shared constants, banner contents and UART transmitter state encoding
// for the bring-up top.
package maxv_pkg;

    localparam int BAUD    = 115200;
    localparam int MSG_LEN = 7;

    // "Hello\r\n"
    localparam logic [7:0] MSG [MSG_LEN] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Clock frequencies below the baud rate clamp to one cycle per bit.
    function automatic int clks_per_bit(input int freq);
        return (freq / BAUD < 1) ? 1 : freq / BAUD;
    endfunction

endpackage

// File: rtl/maxv_if.sv
// Byte handshake between the banner sequencer and the UART transmitter.
// A byte transfers on any rising edge where valid and ready are both high;
// the master holds data stable while valid is high and ready is low.
interface maxv_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/maxv_uart_tx.sv
// TX-only 8N1 UART: start bit, eight data bits LSB first, one stop bit.
// The line is driven straight from a flop so it never glitches.
module uart_tx
    import maxv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q,    tx_d;
    logic          bit_done;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign bit_done = (cnt_q == CNT_MAX);

    // tx_d is the level the line takes on the next edge, so each state
    // transition also decides the first level of the following bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                tx_d    = 1'b1;
                cnt_d   = '0;
                bit_d   = '0;
                if (valid_i) begin
                    shift_d = data_i;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/maxv_top.sv
// Board top: endlessly sends "Hello\r\n" over the UART and shows the low six
// bits of the sent-byte count on active-low LEDs.
module maxv_top
    import maxv_pkg::*;
#(
    parameter int FREQ = 27_000_000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    output logic [5:0] led_o,
    output logic       uart_tx_o
);

    localparam int         CLKS_PER_BIT = clks_per_bit(FREQ);
    localparam logic [2:0] IDX_LAST     = 3'(MSG_LEN - 1);

    maxv_if hs ();

    logic [2:0] idx_q,      idx_d;
    logic [5:0] byte_cnt_q, byte_cnt_d;
    logic [5:0] led_q,      led_d;
    logic       hs_fire;

    // The banner source never stalls; the transmitter paces it.
    assign hs.valid = 1'b1;
    assign hs.data  = MSG[idx_q];
    assign hs_fire  = hs.valid & hs.ready;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idx_q      <= '0;
            byte_cnt_q <= '0;
            led_q      <= 6'h3F;
        end else begin
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            led_q      <= led_d;
        end
    end

    always_comb begin
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        if (hs_fire) begin
            idx_d      = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            byte_cnt_d = byte_cnt_q + 6'd1;
        end
        // LEDs follow the count in the same cycle it changes.
        led_d = ~byte_cnt_d;
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .data_i  (hs.data),
        .valid_i (hs.valid),
        .ready_o (hs.ready),
        .tx_o    (uart_tx_o)
    );

    assign led_o = led_q;

endmodule

// File: tb/tb_maxv_top.sv
// Directed bench for maxv_top: three instances at different clock/baud
// ratios share one clock and reset; frames are decoded on the falling edge.
module tb_maxv_top;

    logic       clk;
    logic       rstn;
    logic [5:0] led1, led2, led3;
    logic       tx1, tx2, tx3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] banner [7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

    // CLKS_PER_BIT = 1
    maxv_top #(.FREQ(115_200)) u_dut1 (
        .clk_i (clk), .rstn_i (rstn), .led_o (led1), .uart_tx_o (tx1)
    );
    // CLKS_PER_BIT = 10
    maxv_top #(.FREQ(1_152_000)) u_dut2 (
        .clk_i (clk), .rstn_i (rstn), .led_o (led2), .uart_tx_o (tx2)
    );
    // below the baud rate: clamps to 1
    maxv_top #(.FREQ(100_000)) u_dut3 (
        .clk_i (clk), .rstn_i (rstn), .led_o (led3), .uart_tx_o (tx3)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic line(input int sel);
        case (sel)
            1:       return tx1;
            2:       return tx2;
            default: return tx3;
        endcase
    endfunction

    // Called on a falling edge; bounded search for the first start-bit cycle.
    task automatic rx_frame(input int sel, input int cpb, output logic [7:0] b, output logic stop_b);
        int waited;
        waited = 0;
        b      = '0;
        while (line(sel) !== 1'b0 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("rx%0d_start", sel), line(sel), 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge clk);
            b[i] = line(sel);
        end
        repeat (cpb) @(negedge clk);
        stop_b = line(sel);
    endtask

    task automatic rx_banner(input int sel, input int cpb, input int n);
        logic [7:0] b;
        logic       s;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(banner[k % 7]);
            rx_frame(sel, cpb, b, s);
            check($sformatf("rx%0d_byte%0d", sel, k), b, exp_q.pop_front());
            check($sformatf("rx%0d_stop%0d", sel, k), s, 1'b1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx1"}, tx1, 1'b1);
        check({tag, "_tx2"}, tx2, 1'b1);
        check({tag, "_tx3"}, tx3, 1'b1);
        check({tag, "_led1"}, led1, 6'h3F);
        check({tag, "_led2"}, led2, 6'h3F);
        check({tag, "_led3"}, led3, 6'h3F);
    endtask

    // Leaves the caller on the first falling edge after the first handshake.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_vals(tag);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        logic       s;
        int         low;

        // Scenario 1: 20 ns clock, reset released at 40 ns
        rstn = 1'b0;
        #20;
        check_reset_vals("rst0");
        #20;
        rstn = 1'b1;
        #1;
        @(negedge clk);
        check("s1_first_low", tx1, 1'b0);
        check("s6_first_low", tx3, 1'b0);
        check("s4_led_first", led1, 6'h3E);
        rx_banner(1, 1, 14);

        // Scenario 6: clamped divider behaves like scenario 1
        do_reset("rst6");
        check("s6_first_low_b", tx3, 1'b0);
        rx_banner(3, 1, 7);

        // Scenario 2: ten cycles per bit, 101-cycle frame
        do_reset("rst2");
        check("s2_start", tx2, 1'b0);
        repeat (99) @(negedge clk);
        check("s2_stop_h", tx2, 1'b1);
        @(negedge clk);
        check("s2_idle_gap", tx2, 1'b1);
        @(negedge clk);
        check("s2_next_start", tx2, 1'b0);
        check("s2_led_two", led2, 6'h3D);
        low = 0;
        while (tx2 === 1'b0 && low < 50) begin
            low++;
            @(negedge clk);
        end
        check("s2_start_len", low, 10);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[i] = tx2;
            repeat (10) @(negedge clk);
        end
        check("s2_stop_e", tx2, 1'b1);
        check("s2_byte_e", b, 8'h65);

        // Scenario 4: LED count and wrap
        do_reset("rst4");
        check("s4_led_1", led1, 6'h3E);
        repeat (11 * 62) @(negedge clk);
        check("s4_led_63", led1, 6'h00);
        repeat (11) @(negedge clk);
        check("s4_led_wrap", led1, 6'h3F);

        // Scenario 5: reset during DATA of the third byte (0x6C, bit 4 low)
        do_reset("rst5");
        repeat (255) @(negedge clk);
        check("s5_pre_abort_tx", tx2, 1'b0);
        check("s5_pre_abort_led", led2, 6'h3C);
        #3;
        rstn = 1'b0;
        #1;
        check("s5_abort_tx", tx2, 1'b1);
        check("s5_abort_led", led2, 6'h3F);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("s5_restart_low", tx2, 1'b0);
        rx_frame(2, 10, b, s);
        check("s5_restart_byte", b, 8'h48);
        check("s5_restart_stop", s, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
